// File: rtl/odd_parity_frame_checker_if.sv
// odd_parity_frame_checker_if: serial bit stream in (bit_in, bit_valid); recovered word, pass/fail, busy and counters out
interface odd_parity_frame_checker_if #(
  parameter int DATA_W = 3,
  parameter int CNT_W  = 8
);
  logic              bit_in;
  logic              bit_valid;
  logic [DATA_W-1:0] data_out;
  logic              frame_done;
  logic              parity_ok;
  logic              busy;
  logic [CNT_W-1:0]  frame_count;
  logic [CNT_W-1:0]  error_count;
  modport master (
    output bit_in, bit_valid,
    input  data_out, frame_done, parity_ok, busy, frame_count, error_count
  );
  modport slave (
    input  bit_in, bit_valid,
    output data_out, frame_done, parity_ok, busy, frame_count, error_count
  );
endinterface

// File: rtl/odd_parity_frame_checker.sv
// odd_parity_frame_checker: MSB-first DATA_W+1 bit odd-parity frame receiver; clk/reset plain, stream and results on bus (slave)
module odd_parity_frame_checker #(
  parameter int DATA_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  odd_parity_frame_checker_if.slave   bus
);
  localparam int IDX_W = DATA_W > 1 ? $clog2(DATA_W) : 1;
  typedef enum logic {S_DATA, S_PAR} state_t;
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  sh_q, sh_d, data_q, data_d;
  logic               acc_q, acc_d, ok_q, ok_d, done_q, done_d, busy_q, busy_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d, ecnt_q, ecnt_d;
  logic               last;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_DATA;
      idx_q   <= '0;
      sh_q    <= '0;
      acc_q   <= 1'b0;
      data_q  <= '0;
      ok_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      fcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      ok_q    <= ok_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      fcnt_q  <= fcnt_d;
      ecnt_q  <= ecnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    data_d  = data_q;
    ok_d    = ok_q;
    done_d  = 1'b0;
    fcnt_d  = fcnt_q;
    ecnt_d  = ecnt_q;
    last    = idx_q == IDX_W'(DATA_W - 1);
    if (bus.bit_valid) begin
      if (state_q == S_DATA) begin
        sh_d    = (sh_q << 1) | DATA_W'(bus.bit_in);
        acc_d   = acc_q ^ bus.bit_in;
        idx_d   = last ? '0 : idx_q + 1'b1;
        state_d = last ? S_PAR : S_DATA;
      end else begin
        data_d  = sh_q;
        ok_d    = acc_q ^ bus.bit_in;
        done_d  = 1'b1;
        fcnt_d  = fcnt_q + 1'b1;
        ecnt_d  = (!ok_d && ecnt_q != '1) ? ecnt_q + 1'b1 : ecnt_q;
        acc_d   = 1'b0;
        idx_d   = '0;
        state_d = S_DATA;
      end
    end
    busy_d = state_d == S_PAR || idx_d != '0;
  end
  assign bus.data_out    = data_q;
  assign bus.frame_done  = done_q;
  assign bus.parity_ok   = ok_q;
  assign bus.busy        = busy_q;
  assign bus.frame_count = fcnt_q;
  assign bus.error_count = ecnt_q;
endmodule
